// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded operands/control from ID and the load-use stall back to ID.
// master = ID stage driving the fields, slave = the ID/EX register.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_alusrc;
    logic [3:0]        id_aluop;
    logic [4:0]        id_shamt;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic              id_memtoreg;
    logic              stall_id;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_alusrc, id_aluop, id_shamt, id_rd_addr, id_regwrite, id_memread,
               id_memwrite, id_memtoreg,
        input  stall_id
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_alusrc, id_aluop, id_shamt, id_rd_addr, id_regwrite, id_memread,
               id_memwrite, id_memtoreg,
        output stall_id
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion, flush handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_if.slave      id,
    input  logic              flush,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mw_regwrite,
    input  logic [REG_AW-1:0] mw_rd_addr,
    input  logic [DATA_W-1:0] mw_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic [4:0]        alu_shamt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] r,
        input logic [DATA_W-1:0] d,
        input logic              ew,
        input logic [REG_AW-1:0] ea,
        input logic [DATA_W-1:0] ed,
        input logic              ww,
        input logic [REG_AW-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (ew && (ea != '0) && (ea == r))
            return ed;
        else if (ww && (wa != '0) && (wa == r))
            return wd;
        else
            return d;
    endfunction

    logic              vld_p1;
    logic              regwrite_p1, memread_p1, memwrite_p1, memtoreg_p1, alusrc_p1;
    logic [REG_AW-1:0] rd_p1, rs_p1, rt_p1;
    logic [3:0]        aluop_p1;
    logic [4:0]        shamt_p1;
    logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;
    logic              bubble;

    // Load in EX whose destination feeds the instruction waiting in ID.
    assign id.stall_id = id.id_valid & vld_p1 & memread_p1 & (rd_p1 != '0) &
                         ((rd_p1 == id.id_rs_addr) |
                          ((rd_p1 == id.id_rt_addr) & ~id.id_alusrc) |
                          id.id_memwrite);

    assign bubble = flush | id.stall_id;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            regwrite_p1  <= 1'b0;
            memread_p1   <= 1'b0;
            memwrite_p1  <= 1'b0;
            memtoreg_p1  <= 1'b0;
            alusrc_p1    <= 1'b0;
            rd_p1        <= '0;
            rs_p1        <= '0;
            rt_p1        <= '0;
            aluop_p1     <= '0;
            shamt_p1     <= '0;
            rs_data_p1   <= '0;
            rt_data_p1   <= '0;
            imm_p1       <= '0;
            bubble_cnt_q <= '0;
        end else if (bubble) begin
            vld_p1       <= 1'b0;
            regwrite_p1  <= 1'b0;
            memread_p1   <= 1'b0;
            memwrite_p1  <= 1'b0;
            memtoreg_p1  <= 1'b0;
            alusrc_p1    <= 1'b0;
            rd_p1        <= '0;
            rs_p1        <= '0;
            rt_p1        <= '0;
            aluop_p1     <= '0;
            shamt_p1     <= '0;
            rs_data_p1   <= '0;
            rt_data_p1   <= '0;
            imm_p1       <= '0;
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end else begin
            vld_p1       <= id.id_valid;
            regwrite_p1  <= id.id_regwrite;
            memread_p1   <= id.id_memread;
            memwrite_p1  <= id.id_memwrite;
            memtoreg_p1  <= id.id_memtoreg;
            alusrc_p1    <= id.id_alusrc;
            rd_p1        <= id.id_rd_addr;
            rs_p1        <= id.id_rs_addr;
            rt_p1        <= id.id_rt_addr;
            aluop_p1     <= id.id_aluop;
            shamt_p1     <= id.id_shamt;
            rs_data_p1   <= id.id_rs_data;
            rt_data_p1   <= id.id_rt_data;
            imm_p1       <= id.id_imm;
        end
    end

    // ---- EX operand forwarding ----
    assign fwd_rs = fwd(rs_p1, rs_data_p1, exm_regwrite, exm_rd_addr, exm_result,
                        mw_regwrite, mw_rd_addr, mw_result);
    assign fwd_rt = fwd(rt_p1, rt_data_p1, exm_regwrite, exm_rd_addr, exm_result,
                        mw_regwrite, mw_rd_addr, mw_result);

    assign alu_a         = fwd_rs;
    assign alu_b         = alusrc_p1 ? imm_p1 : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_op        = aluop_p1;
    assign alu_shamt     = shamt_p1;
    assign ex_valid      = vld_p1;
    assign ex_regwrite   = regwrite_p1;
    assign ex_memread    = memread_p1;
    assign ex_memwrite   = memwrite_p1;
    assign ex_memtoreg   = memtoreg_p1;
    assign ex_rd_addr    = rd_p1;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic        exm_regwrite, mw_regwrite;
    logic [4:0]  exm_rd_addr, mw_rd_addr;
    logic [31:0] exm_result, mw_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt, ex_rd_addr;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [15:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) idb ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id(idb.slave), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mw_regwrite(mw_regwrite), .mw_rd_addr(mw_rd_addr), .mw_result(mw_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_rd_addr(ex_rd_addr), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, mr, mw, mt, alusrc;
        logic [4:0]  rd, rs, rt, shamt;
        logic [3:0]  op;
        logic [31:0] rsd, rtd, imm;
    } ex_t;

    ex_t m;
    int  bcnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] d);
        if (exm_regwrite && exm_rd_addr != 0 && exm_rd_addr == r) return exm_result;
        if (mw_regwrite && mw_rd_addr != 0 && mw_rd_addr == r) return mw_result;
        return d;
    endfunction

    function automatic logic m_stall();
        logic uses;
        uses = (m.rd == idb.id_rs_addr) || (m.rd == idb.id_rt_addr && !idb.id_alusrc)
               || idb.id_memwrite;
        return idb.id_valid && m.valid && m.mr && m.rd != 0 && uses;
    endfunction

    task automatic clear_model();
        m = '{default: 0};
        bcnt = 0;
    endtask

    task automatic idle();
        idb.id_valid = 0; idb.id_rs_addr = 0; idb.id_rt_addr = 0; idb.id_rs_data = 0;
        idb.id_rt_data = 0; idb.id_imm = 0; idb.id_alusrc = 0; idb.id_aluop = 0;
        idb.id_shamt = 0; idb.id_rd_addr = 0; idb.id_regwrite = 0; idb.id_memread = 0;
        idb.id_memwrite = 0; idb.id_memtoreg = 0;
        flush = 0; exm_regwrite = 0; exm_rd_addr = 0; exm_result = 0;
        mw_regwrite = 0; mw_rd_addr = 0; mw_result = 0;
    endtask

    task automatic compare_all();
        check("stall_id", idb.stall_id, m_stall());
        check("alu_a", alu_a, m_fwd(m.rs, m.rsd));
        check("alu_b", alu_b, m.alusrc ? m.imm : m_fwd(m.rt, m.rtd));
        check("store_data", ex_store_data, m_fwd(m.rt, m.rtd));
        check("alu_op", alu_op, m.op);
        check("alu_shamt", alu_shamt, m.shamt);
        check("ctrl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
              {m.valid, m.rw, m.mr, m.mw, m.mt});
        check("rd", ex_rd_addr, m.rd);
        check("bubble_cnt", bubble_cnt, (bcnt > 65535) ? 65535 : bcnt);
    endtask

    // Inputs are already driven (at negedge); check, then advance model through one edge.
    task automatic cycle();
        ex_t nx;
        int  nb;
        #1 compare_all();
        nb = bcnt;
        if (flush || m_stall()) begin
            nx = '{default: 0};
            nb = bcnt + 1;
        end else begin
            nx.valid = idb.id_valid;    nx.rw = idb.id_regwrite;  nx.mr = idb.id_memread;
            nx.mw = idb.id_memwrite;    nx.mt = idb.id_memtoreg;  nx.alusrc = idb.id_alusrc;
            nx.rd = idb.id_rd_addr;     nx.rs = idb.id_rs_addr;   nx.rt = idb.id_rt_addr;
            nx.shamt = idb.id_shamt;    nx.op = idb.id_aluop;     nx.rsd = idb.id_rs_data;
            nx.rtd = idb.id_rt_data;    nx.imm = idb.id_imm;
        end
        @(posedge clk);
        m = nx;
        bcnt = nb;
        @(negedge clk);
    endtask

    task automatic put_instr(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                             input logic [31:0] rtd, input logic [4:0] rd, input logic [3:0] op,
                             input logic alusrc, input logic memread);
        idb.id_valid = 1; idb.id_rs_addr = rs; idb.id_rs_data = rsd; idb.id_rt_addr = rt;
        idb.id_rt_data = rtd; idb.id_rd_addr = rd; idb.id_aluop = op; idb.id_alusrc = alusrc;
        idb.id_memread = memread; idb.id_regwrite = 1; idb.id_memtoreg = memread;
        idb.id_memwrite = 0; idb.id_imm = 32'h0000_0100; idb.id_shamt = 5'd3;
    endtask

    initial begin
        int b0;
        idle();
        clear_model();
        repeat (2) @(negedge clk);
        #1 check("reset_valid", ex_valid, 0);
        rst_n = 1;
        @(negedge clk);

        // Randomized traffic; small register range so hazards and forwards are frequent.
        for (int i = 0; i < 1500; i++) begin
            idb.id_valid    = ($urandom_range(0, 3) != 0);
            idb.id_rs_addr  = 5'($urandom_range(0, 3));
            idb.id_rt_addr  = 5'($urandom_range(0, 3));
            idb.id_rd_addr  = 5'($urandom_range(0, 3));
            idb.id_rs_data  = $urandom;
            idb.id_rt_data  = $urandom;
            idb.id_imm      = $urandom;
            idb.id_alusrc   = 1'($urandom);
            idb.id_aluop    = 4'($urandom);
            idb.id_shamt    = 5'($urandom);
            idb.id_regwrite = 1'($urandom);
            idb.id_memread  = ($urandom_range(0, 2) == 0);
            idb.id_memwrite = ($urandom_range(0, 4) == 0);
            idb.id_memtoreg = 1'($urandom);
            flush           = ($urandom_range(0, 7) == 0);
            exm_regwrite    = 1'($urandom);
            exm_rd_addr     = 5'($urandom_range(0, 3));
            exm_result      = $urandom;
            mw_regwrite     = 1'($urandom);
            mw_rd_addr      = 5'($urandom_range(0, 3));
            mw_result       = $urandom;
            cycle();
        end

        // Mid-run asynchronous reset with a valid instruction registered.
        idle();
        put_instr(5'd1, 32'hAB, 5'd2, 32'hCD, 5'd7, 4'b0110, 1'b0, 1'b0);
        cycle();
        check("pre_reset_valid", ex_valid, 1);
        idle();
        rst_n = 0;
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_alu_a", alu_a, 0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        cycle();

        // Load-use: lw $4 in EX, dependent addu in ID.
        put_instr(5'd1, 32'h0, 5'd0, 32'h0, 5'd4, 4'b0010, 1'b1, 1'b1);
        cycle();
        put_instr(5'd4, 32'h999, 5'd5, 32'h7, 5'd6, 4'b0010, 1'b0, 1'b0);
        #1 check("lu_stall", idb.stall_id, 1);
        cycle();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_cnt", bubble_cnt, 1);
        check("lu_stall_released", idb.stall_id, 0);
        cycle();
        mw_regwrite = 1; mw_rd_addr = 5'd4; mw_result = 32'h44;
        #1 check("lu_fwd_mw", alu_a, 32'h44);
        check("lu_valid", ex_valid, 1);
        cycle();
        idle();

        // Flush coinciding with a load-use stall.
        put_instr(5'd1, 32'h0, 5'd0, 32'h0, 5'd4, 4'b0010, 1'b1, 1'b1);
        cycle();
        put_instr(5'd4, 32'h1, 5'd5, 32'h2, 5'd6, 4'b0010, 1'b0, 1'b0);
        flush = 1;
        b0 = bcnt;
        #1 check("fs_stall", idb.stall_id, 1);
        cycle();
        check("fs_regwrite", ex_regwrite, 0);
        check("fs_cnt", bubble_cnt, 16'(b0 + 1));
        idle();

        // Plain capture, no forwarding.
        put_instr(5'd1, 32'd5, 5'd2, 32'd7, 5'd8, 4'b0010, 1'b0, 1'b0);
        cycle();
        idle();
        #1 check("cap_a", alu_a, 5);
        check("cap_b", alu_b, 7);
        check("cap_op", alu_op, 4'b0010);
        cycle();

        // Both stages target $3: EX/MEM wins.
        put_instr(5'd3, 32'hAA, 5'd0, 32'h0, 5'd9, 4'b0000, 1'b0, 1'b0);
        cycle();
        idle();
        exm_regwrite = 1; exm_rd_addr = 5'd3; exm_result = 32'h10;
        mw_regwrite = 1; mw_rd_addr = 5'd3; mw_result = 32'h20;
        #1 check("dfwd_a", alu_a, 32'h10);
        cycle();
        // Same with $0: never forwarded.
        put_instr(5'd0, 32'h55, 5'd0, 32'h66, 5'd9, 4'b0001, 1'b0, 1'b0);
        exm_regwrite = 0; mw_regwrite = 0;
        cycle();
        idle();
        exm_regwrite = 1; exm_rd_addr = 5'd0; exm_result = 32'h10;
        mw_regwrite = 1; mw_rd_addr = 5'd0; mw_result = 32'h20;
        #1 check("zero_a", alu_a, 32'h55);
        check("zero_store", ex_store_data, 32'h66);
        cycle();
        idle();

        // Saturation: 2^16+3 flushes.
        rst_n = 0;
        #1 clear_model();
        @(negedge clk);
        rst_n = 1;
        flush = 1;
        repeat (65536 + 3) @(posedge clk);
        @(negedge clk);
        #1 check("sat_cnt", bubble_cnt, 16'hFFFF);
        check("sat_valid", ex_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core; sits directly upstream of the EX-stage ALU and drives its A, B, ALUOp and shift-offset inputs.
- Captures decoded operands and control from ID each cycle.
- Applies EX/MEM and MEM/WB result forwarding on its registered operands, detects load-use hazards (stalls ID, inserts a bubble) and honours branch/jump flushes.

Parameters:
- DATA_W, 32, operand/result width; must match ALU width.
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- id_valid  input  1  ID holds a real instruction.
- id_rs_addr  input  REG_AW  source register rs.
- id_rt_addr  input  REG_AW  source register rt.
- id_rs_data  input  DATA_W  register-file read of rs.
- id_rt_data  input  DATA_W  register-file read of rt.
- id_imm  input  DATA_W  extended immediate.
- id_alusrc  input  1  1 selects imm as ALU B.
- id_aluop  input  4  ALU opcode (0000 AND, 0001 OR, 0010 ADDU, 0011 ADD, 0110 SUB).
- id_shamt  input  5  shift offset.
- id_rd_addr  input  REG_AW  destination register.
- id_regwrite, id_memread, id_memwrite, id_memtoreg  input  1 each  control bits.
- flush  input  1  kill the instruction entering EX this cycle.
- exm_regwrite  input  1  EX/MEM write enable.
- exm_rd_addr  input  REG_AW  EX/MEM destination.
- exm_result  input  DATA_W  EX/MEM ALU result.
- mw_regwrite  input  1  MEM/WB write enable.
- mw_rd_addr  input  REG_AW  MEM/WB destination.
- mw_result  input  DATA_W  MEM/WB writeback value.
- stall_id  output  1  hold PC and IF/ID (combinational).
- alu_a, alu_b  output  DATA_W  ALU operands (forwarded).
- alu_op  output  4  to ALU ALUOp.
- alu_shamt  output  5  to ALU shift_offset.
- ex_store_data  output  DATA_W  forwarded rt for stores.
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  output  1 each  registered control.
- ex_rd_addr  output  REG_AW  registered destination.
- bubble_cnt  output  CNT_W  count of bubbles inserted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registered fields cleared: valid=0, all control bits=0, rd=0, aluop=0000, shamt=0, rs/rt/imm/data=0.
  - bubble_cnt=0.
  - Outputs therefore show a bubble with alu_a=alu_b=0.
  - Deassertion is taken on the following clock edge.
- Hazard detection (combinational):
  - stall_id = id_valid & ex_valid & ex_memread & (ex_rd_addr!=0) & (ex_rd_addr==id_rs_addr | (ex_rd_addr==id_rt_addr & !id_alusrc | id_memwrite)).
- Per rising edge, priority order:
  - flush=1: load a bubble (all fields cleared as at reset); counts as a bubble.
  - else stall_id=1: load a bubble; counts as a bubble. ID holds, so the same instruction is re-presented next cycle.
  - else: capture every id_* field; valid=id_valid.
- Bubble counter:
  - bubble_cnt increments by 1 per bubble inserted.
  - Saturates at all-ones; never wraps.
- Forwarding (combinational on registered rs/rt, applies to both operands):
  - 1) If exm_regwrite & exm_rd_addr!=0 & exm_rd_addr==reg, use exm_result.
  - 2) Else if mw_regwrite & mw_rd_addr!=0 & mw_rd_addr==reg, use mw_result.
  - 3) Else use the captured data.
  - Register 0 is never forwarded.
  - EX/MEM wins when both stages match.
- Operand selection:
  - alu_a = fwd(rs).
  - alu_b = ex_alusrc ? imm : fwd(rt).
  - ex_store_data = fwd(rt) always.
  - alu_op and alu_shamt are direct register outputs.
- Latency: 1 cycle ID to EX.
- Register-file same-cycle WB/read coherence is handled by the register file (write-before-read), not by this block.
- Simultaneous flush and stall_id: flush wins; a single bubble is counted once.
- Invalid ID slot (id_valid=0) never raises stall_id.

Test Plan:
- Reset: hold rst_n=0 mid-run with a valid instruction registered → ex_valid=0, alu_op=0000, bubble_cnt=0 immediately, before any clock edge.
- Plain capture: rs=$1 data 5, rt=$2 data 7, aluop=0010, alusrc=0, no forwarding → next cycle alu_a=5, alu_b=7, alu_op=0010.
- Double forward: EX/MEM writes $3=0x10 and MEM/WB writes $3=0x20 while EX rs=$3 → alu_a=0x10. Same case with rd=$0 → captured data used.
- Load-use: lw $4 in EX, ID addu uses rs=$4 → stall_id=1 for exactly one cycle, bubble in EX, bubble_cnt 0→1. Next cycle addu enters and takes $4 from mw_result.
- Flush during stall: flush=1 and stall_id=1 on the same edge → one bubble, bubble_cnt +1, ex_regwrite=0.
- Saturation: drive 2^CNT_W+3 flushes → bubble_cnt stays at 0xFFFF.
